// File: rtl/mul_sum.sv
// Registered unsigned multiply-accumulate step: res <= ai*xni + resprev on every rising clk.
// Define MUL_SUM_SAT_EN to clamp the sum to 2^(2N)-1 so a 2N-bit feedback path never wraps.
module mul_sum #(
   parameter int SZin = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SZin:0]     ai,
   input  logic [SZin:0]     xni,
   input  logic [2*SZin+1:0] resprev,
   output logic [2*SZin+2:0] res
);

   localparam int N = SZin + 1;

   logic [2*N-1:0] prod;
   logic [2*N:0]   sum;
   logic [2*N:0]   next_res;

   // Operands are widened before multiplying so the product keeps all 2N bits.
   always_comb begin
      prod = {{N{1'b0}}, ai} * {{N{1'b0}}, xni};
      sum  = {1'b0, prod} + {1'b0, resprev};
`ifdef MUL_SUM_SAT_EN
      next_res = sum[2*N] ? {1'b0, {(2*N){1'b1}}} : sum;
`else
      next_res = sum;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) res <= '0;
      else      res <= next_res;
   end

endmodule

// File: tb/tb_mul_sum.sv
// Randomised self-checking bench for mul_sum (SZin=3); a running model is compared on every falling edge.
module tb_mul_sum;

   localparam int SZin    = 3;
   localparam int N       = SZin + 1;
   localparam int SUM_MAX = (1 << (2 * N)) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [SZin:0]     ai = '0;
   logic [SZin:0]     xni = '0;
   logic [2*SZin+1:0] resprev = '0;
   logic [2*SZin+2:0] res;

   int exp_res = 0;
   int check_count = 0;
   int pass_count = 0;
   bit model_on = 1'b0;

   mul_sum #(.SZin(SZin)) dut (
      .clk(clk),
      .rst(rst),
      .ai(ai),
      .xni(xni),
      .resprev(resprev),
      .res(res)
   );

   always #5 clk = ~clk;

   function automatic int model_sum(int a, int x, int p);
      int s;
      s = a * x + p;
`ifdef MUL_SUM_SAT_EN
      if (s > SUM_MAX) s = SUM_MAX;
`endif
      return s;
   endfunction

   // Reference: reset forces zero at once, otherwise each rising edge latches the arithmetic sum.
   always @(posedge clk or negedge rst) begin
      if (rst) exp_res = model_sum(int'(ai), int'(xni), int'(resprev));
      else     exp_res = 0;
   end

   task automatic check(input string name, input int actual, input int expected);
      check_count++;
      if (actual == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
   endtask

   task automatic check_output(input string name, input int expected);
      check(name, int'(res), expected);
   endtask

   task automatic apply_stimulus(input int a, input int x, input int p);
      @(negedge clk);
      ai      = a[SZin:0];
      xni     = x[SZin:0];
      resprev = p[2*SZin+1:0];
   endtask

   always @(negedge clk) begin
      if (model_on) check("model", int'(res), exp_res);
   end

   initial begin
      int acc_a[3];
      int acc_x[3];
      int acc_e[3];
      acc_a = '{1, 2, 3};
      acc_x = '{2, 5, 9};
      acc_e = '{2, 12, 39};

      ai = 4'd7; xni = 4'd9; resprev = 8'd3;
      #1;
      check_output("reset_initial", 0);
      repeat (3) begin
         @(negedge clk);
         check_output("reset_hold", 0);
      end
      model_on = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("reset_release", 66);

      apply_stimulus(3, 5, 10);
      @(negedge clk);
      check_output("basic_25", 25);
      #2;
      ai = 4'd9; xni = 4'd9; resprev = 8'd100;
      #2;
      check_output("hold_between_edges", 25);
      @(negedge clk);
      check_output("next_edge_181", 181);

      apply_stimulus(15, 15, 255);
      @(negedge clk);
`ifdef MUL_SUM_SAT_EN
      check_output("max_operands", 255);
`else
      check_output("max_operands", 480);
`endif

      apply_stimulus(0, 12, 77);
      @(negedge clk);
      check_output("zero_coef", 77);
      apply_stimulus(1, 1, 0);
      @(negedge clk);
      check_output("unit_product", 1);

      apply_stimulus(acc_a[0], acc_x[0], 0);
      @(negedge clk);
      check_output("accum_0", acc_e[0]);
      for (int i = 1; i < 3; i++) begin
         ai      = acc_a[i][SZin:0];
         xni     = acc_x[i][SZin:0];
         resprev = res[2*SZin+1:0];
         @(negedge clk);
         check_output("accum_step", acc_e[i]);
      end

      #2;
      rst = 1'b0;
      #1;
      check_output("async_reset", 0);
      @(negedge clk);
      check_output("reset_across_edge", 0);
      rst     = 1'b1;
      ai      = 4'd2;
      xni     = 4'd3;
      resprev = res[2*SZin+1:0];
      @(negedge clk);
      check_output("restart_after_reset", 6);

      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ai  = 4'($urandom_range(0, 15));
         xni = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) resprev = res[2*SZin+1:0];
         else                           resprev = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) begin
            #2;
            rst = 1'b0;
            #1;
            check_output("rand_async_reset", 0);
            #1;
            rst = 1'b1;
         end
      end
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
